pow_engine: RTL

Exponentiation engine computing p = x^a mod 2^WIDTH by right-to-left square-and-multiply. It sits directly downstream of the CPU-facing exponent interface, which loads x and a, pulses `enable`, waits for `ready`, and then reads `p`. The engine accepts one job at a time and holds its result until the next job completes.

---
 rtl/pow_engine_if.sv | 13 +
 rtl/pow_engine.sv | 79 +++++++
 2 files changed

// File: rtl/pow_engine_if.sv
// rtl/pow_engine_if.sv - start/operand/result bundle between the exponent front end and pow_engine
interface pow_engine_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] p;
    logic             ready;

    modport master (output enable, output x, output a, input p, input ready);
    modport slave  (input enable, input x, input a, output p, output ready);
endinterface

// File: rtl/pow_engine.sv
// rtl/pow_engine.sv - x^a mod 2^WIDTH by right-to-left square-and-multiply
// Optional macro POW_EARLY_EXIT_EN: stop once the remaining exponent is zero.
module pow_engine #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    pow_engine_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;

    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_base_next;
    logic [WIDTH-1:0] w_e_next;
    logic             w_last;

    // Both products use pre-update values; only the low WIDTH bits are kept.
    assign w_acc_next  = r_e[0] ? r_acc * r_base : r_acc;
    assign w_base_next = r_base * r_base;
    assign w_e_next    = r_e >> 1;

`ifdef POW_EARLY_EXIT_EN
    assign w_last = (w_e_next == '0) || (r_cnt == LAST_CNT);
`else
    assign w_last = (r_cnt == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_acc   <= '0;
            r_e     <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_base  <= bus.x;
                        r_e     <= bus.a;
                        r_acc   <= WIDTH'(1);
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_base <= w_base_next;
                    r_e    <= w_e_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_p     <= w_acc_next;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.p     = r_p;
    assign bus.ready = r_ready;
endmodule
